// File: rtl/naive_uart_pkg.sv
// Shared register map, TX state encoding and address decode for the naive_bus UART TX slave.
package naive_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Only the first 16 bytes of the window are mapped; addr[1:0] is don't-care.
  function automatic logic is_reg(input logic [31:0] addr, input logic [1:0] sel);
    return (addr[31:4] == 28'd0) && (addr[3:2] == sel);
  endfunction

endpackage

// File: rtl/naive_bus.sv
// naive_bus: split read/write request-grant bus with byte enables.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
                  input  rd_gnt, rd_data, wr_gnt);
  modport slave  (input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
                  output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/naive_bus_uart_tx_slave_fifo.sv
// First-word-fall-through synchronous FIFO; level runs 0..DEPTH, pointers wrap mod DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_L  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + ONE_P;
      if (pop_i)  rptr_q <= rptr_q + ONE_P;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + ONE_L;
        2'b01:   level_q <= level_q - ONE_L;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (level_q == FULL_L);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
endmodule

// File: rtl/naive_bus_uart_tx_slave.sv
// naive_bus slave wrapping an 8N1 UART transmitter fed by a TX FIFO.
module naive_bus_uart_tx_slave import naive_uart_pkg::*; #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic     clk,
  input  logic     rstn,
  naive_bus.slave  bus,
  output logic     uart_tx,
  output logic     tx_busy
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_tx, wr_baud, wr_fire, push, pop, full, empty;
  logic [7:0]    fifo_rdata;
  logic [LW-1:0] level;
  logic [31:0]   rd_word, rd_data_q;
  logic [15:0]   baud_q, baud_d, div_now;
  tx_state_t     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d, busy_q, busy_d, tick;
  logic          unused_bits;

  assign unused_bits = ^{bus.rd_be, bus.wr_data[31:16], bus.wr_be[3:2]};

  assign wr_tx      = is_reg(bus.wr_addr, REG_TXDATA);
  assign wr_baud    = is_reg(bus.wr_addr, REG_BAUD);
  // Uses the registered full flag: a pop this cycle does not open the gate.
  assign bus.wr_gnt = bus.wr_req & ~(wr_tx & full);
  assign wr_fire    = bus.wr_req & bus.wr_gnt;
  assign push       = wr_fire & wr_tx & bus.wr_be[0];
  assign bus.rd_gnt = bus.rd_req;
  assign bus.rd_data = rd_data_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push_i(push), .wdata_i(bus.wr_data[7:0]), .pop_i(pop),
    .rdata_o(fifo_rdata), .full_o(full), .empty_o(empty), .level_o(level)
  );

  always_comb begin
    baud_d = baud_q;
    if (wr_fire && wr_baud) begin
      if (bus.wr_be[0]) baud_d[7:0]  = bus.wr_data[7:0];
      if (bus.wr_be[1]) baud_d[15:8] = bus.wr_data[15:8];
    end
  end

  always_comb begin
    rd_word = '0;
    if (is_reg(bus.rd_addr, REG_STATUS))
      rd_word = {16'b0, 8'(level), 5'b0, busy_q, full, empty};
    else if (is_reg(bus.rd_addr, REG_BAUD))
      rd_word = {16'b0, baud_q};
  end

  assign div_now = (baud_q == '0) ? 16'd1 : baud_q;
  // div_q is latched per bit so a BAUD_DIV change takes effect at the next boundary.
  assign tick    = (cnt_q == div_q - 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    if (tick) begin
      cnt_d = '0;
      div_d = div_now;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_rdata;
          div_d   = div_now;
          state_d = START;
        end
      end
      START: if (tick) begin
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick) begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_rdata;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) | ~empty | push;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
      baud_q    <= 16'(DEFAULT_DIV);
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 16'd1;
      bit_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      if (bus.rd_req) rd_data_q <= rd_word;
      baud_q  <= baud_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = busy_q;
endmodule

// File: tb/tb_naive_bus_uart_tx_slave.sv
// Directed bench: register-access vector table plus hand-written serial/backpressure/reset sequences.
module tb_naive_bus_uart_tx_slave;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic uart_tx, tx_busy;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  naive_bus bus_if();

  naive_bus_uart_tx_slave #(.FIFO_DEPTH(16), .DEFAULT_DIV(868)) dut (
    .clk(clk), .rstn(rstn), .bus(bus_if), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int max_wait, output bit granted);
    bus_if.wr_req  = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    bus_if.wr_be   = be;
    granted = 1'b0;
    #1;
    for (int i = 0; i <= max_wait; i++) begin
      if (bus_if.wr_gnt) begin
        granted = 1'b1;
        break;
      end
      tick1();
    end
    if (granted) tick1();
    bus_if.wr_req = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = a;
    bus_if.rd_be   = 4'hF;
    tick1();
    bus_if.rd_req = 1'b0;
    d = bus_if.rd_data;
  endtask

  initial begin
    bit          g;
    logic [31:0] d;
    logic [9:0]  fr1;
    logic [19:0] fr2;
    logic        e;
    int          n;
    bit          bad;

    bus_if.rd_req = 1'b0; bus_if.rd_addr = '0; bus_if.rd_be = '0;
    bus_if.wr_req = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0; bus_if.wr_be = '0;

    vecs[0]  = '{0, 32'h04, 32'h0,        4'h0, 32'h0000_0001};
    vecs[1]  = '{0, 32'h08, 32'h0,        4'h0, 32'd868};
    vecs[2]  = '{0, 32'h00, 32'h0,        4'h0, 32'h0};
    vecs[3]  = '{1, 32'h08, 32'hFFFF_FF10, 4'h1, 32'h0};
    vecs[4]  = '{0, 32'h08, 32'h0,        4'h0, 32'h0000_0310};
    vecs[5]  = '{1, 32'h08, 32'h0000_AB00, 4'h2, 32'h0};
    vecs[6]  = '{0, 32'h08, 32'h0,        4'h0, 32'h0000_AB10};
    vecs[7]  = '{1, 32'h08, 32'h1234_0000, 4'hC, 32'h0};
    vecs[8]  = '{0, 32'h0B, 32'h0,        4'h0, 32'h0000_AB10};
    vecs[9]  = '{1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[10] = '{0, 32'h20, 32'h0,        4'h0, 32'h0};
    vecs[11] = '{1, 32'h28, 32'h0000_0005, 4'hF, 32'h0};
    vecs[12] = '{0, 32'h08, 32'h0,        4'h0, 32'h0000_AB10};
    vecs[13] = '{1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[14] = '{0, 32'h0C, 32'h0,        4'h0, 32'h0};
    vecs[15] = '{1, 32'h10, 32'h0000_0041, 4'hF, 32'h0};
    vecs[16] = '{1, 32'h00, 32'h0000_0042, 4'hE, 32'h0};
    vecs[17] = '{0, 32'h04, 32'h0,        4'h0, 32'h0000_0001};

    repeat (3) @(posedge clk);
    #1;
    chk("reset uart_tx", {31'b0, uart_tx}, 32'h1);
    chk("reset tx_busy", {31'b0, tx_busy}, 32'h0);
    rstn = 1'b1;
    tick1();

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) begin
        bus_wr(vecs[i].addr, vecs[i].data, vecs[i].be, 0, g);
        chk($sformatf("vec%0d wr_gnt", i), {31'b0, g}, 32'h1);
      end else begin
        bus_rd(vecs[i].addr, d);
        chk($sformatf("vec%0d rd_data", i), d, vecs[i].exp);
      end
    end
    chk("idle uart_tx", {31'b0, uart_tx}, 32'h1);

    // Single frame, BAUD_DIV=4, 0x55
    bus_wr(32'h08, 32'd4, 4'hF, 0, g);
    bus_wr(32'h00, 32'h55, 4'h1, 0, g);
    fr1 = {1'b1, 8'h55, 1'b0};
    for (int k = 1; k <= 42; k++) begin
      tick1();
      e = (k == 1 || k == 42) ? 1'b1 : fr1[(k-2)/4];
      chk($sformatf("frame55 tx k=%0d", k), {31'b0, uart_tx}, {31'b0, e});
      if (k == 41) chk("frame55 busy in stop", {31'b0, tx_busy}, 32'h1);
      if (k == 42) chk("frame55 busy after stop", {31'b0, tx_busy}, 32'h0);
    end

    // Back-to-back frames, BAUD_DIV=2
    bus_wr(32'h08, 32'd2, 4'hF, 0, g);
    bus_wr(32'h00, 32'hA5, 4'h1, 0, g);
    bus_wr(32'h00, 32'h3C, 4'h1, 0, g);
    fr2 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    for (int k = 2; k <= 42; k++) begin
      tick1();
      e = (k == 42) ? 1'b1 : fr2[(k-2)/2];
      chk($sformatf("pair tx k=%0d", k), {31'b0, uart_tx}, {31'b0, e});
    end
    chk("pair busy after", {31'b0, tx_busy}, 32'h0);

    // Fill FIFO at BAUD_DIV=1000 and hit backpressure
    bus_wr(32'h08, 32'd1000, 4'hF, 0, g);
    for (int i = 0; i < 17; i++) begin
      bus_wr(32'h00, 32'h30 + i, 4'h1, 0, g);
      chk($sformatf("fill%0d wr_gnt", i), {31'b0, g}, 32'h1);
    end
    bus_if.wr_req = 1'b1; bus_if.wr_addr = 32'h0; bus_if.wr_data = 32'h99; bus_if.wr_be = 4'h1;
    bus_if.rd_req = 1'b1; bus_if.rd_addr = 32'h4;
    #1;
    chk("full wr_gnt blocked", {31'b0, bus_if.wr_gnt}, 32'h0);
    tick1();
    bus_if.rd_req = 1'b0;
    chk("full STATUS", bus_if.rd_data, 32'h0000_1006);
    chk("still blocked", {31'b0, bus_if.wr_gnt}, 32'h0);
    n = 0;
    while (!bus_if.wr_gnt && n < 12000) begin
      tick1();
      n++;
    end
    chk("unblock after pop", {31'b0, bus_if.wr_gnt}, 32'h1);
    tick1();
    bus_if.wr_req = 1'b0;
    bus_rd(32'h04, d);
    chk("refilled STATUS", d, 32'h0000_1006);
    rstn = 1'b0;
    #1;
    chk("reset while full tx", {31'b0, uart_tx}, 32'h1);
    tick1();
    rstn = 1'b1;
    tick1();

    // Reset mid-DATA
    bus_rd(32'h08, d);
    chk("baud after reset", d, 32'd868);
    bus_wr(32'h08, 32'd4, 4'hF, 0, g);
    bus_wr(32'h00, 32'h00, 4'h1, 0, g);
    bus_wr(32'h00, 32'hF0, 4'h1, 0, g);
    repeat (10) tick1();
    chk("mid DATA tx low", {31'b0, uart_tx}, 32'h0);
    rstn = 1'b0;
    #1;
    chk("async reset tx", {31'b0, uart_tx}, 32'h1);
    chk("async reset busy", {31'b0, tx_busy}, 32'h0);
    tick1();
    rstn = 1'b1;
    bus_rd(32'h04, d);
    chk("post reset STATUS", d, 32'h0000_0001);
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick1();
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    chk("no frame resumes", {31'b0, bad}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
